pool_serializer: RTL and testbench

Downstream stage of the 2-D max-pool block. Captures one flattened pooled vector (the pool's `data_out`/`data_out_valid` bus) into a holding register. Streams it out one element per cycle over a valid/ready handshake toward the fully-connected input stage. Because the pool stage has no backpressure, the block also flags any vector that arrives while it is still busy.

---
 rtl/pool_serializer.sv | 92 +++++++++
 tb/tb_pool_serializer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/pool_serializer.sv
// pool_serializer: captures one flattened pooled vector and streams it out
// one element per cycle over a valid/ready handshake. A vector arriving while
// the block cannot take it is dropped and flagged with a sticky overflow bit.
module pool_serializer #(
   parameter int ELEM_WIDTH = 16,
   parameter int NUM_ELEMS  = 8,
   parameter int IDX_WIDTH  = (NUM_ELEMS > 1) ? $clog2(NUM_ELEMS) : 1
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [NUM_ELEMS*ELEM_WIDTH-1:0] data_in,
   input  logic                            data_valid,
   output logic                            in_ready,
   output logic [ELEM_WIDTH-1:0]           elem_out,
   output logic                            elem_valid,
   input  logic                            elem_ready,
   output logic [IDX_WIDTH-1:0]            elem_idx,
   output logic                            elem_last,
   output logic                            overflow
);

   localparam int unsigned          VEC_WIDTH = NUM_ELEMS * ELEM_WIDTH;
   localparam logic [IDX_WIDTH-1:0] LAST_IDX  = IDX_WIDTH'(NUM_ELEMS - 1);

   typedef enum logic {
      S_IDLE   = 1'b0,
      S_STREAM = 1'b1
   } state_t;

   state_t                 r_state;
   logic [IDX_WIDTH-1:0]   r_idx;
   logic [VEC_WIDTH-1:0]   r_hold;
   logic                   r_overflow;

   logic                   w_at_last;
   logic                   w_accept;
   logic [VEC_WIDTH-1:0]   w_shifted;

   // Decode handshake-side outputs from the registered state.
   assign w_at_last  = (r_idx == LAST_IDX);
   assign elem_valid = (r_state == S_STREAM);
   assign elem_last  = w_at_last && elem_valid;
   assign elem_idx   = r_idx;
   assign overflow   = r_overflow;

   // Ready when empty, or when the final element is leaving this cycle.
   assign in_ready = (r_state == S_IDLE) || ((r_state == S_STREAM) && elem_ready && w_at_last);
   assign w_accept = data_valid && in_ready;

   // Select the current element from the holding register.
   assign w_shifted = r_hold >> (32'(r_idx) * 32'(ELEM_WIDTH));
   assign elem_out  = w_shifted[ELEM_WIDTH-1:0];

   // Control FSM: load, step index on handshake, reload or retire on last element.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_idx      <= '0;
         r_hold     <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (data_valid && !in_ready) begin
            r_overflow <= 1'b1;
         end
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_hold  <= data_in;
                  r_idx   <= '0;
                  r_state <= S_STREAM;
               end
            end
            S_STREAM: begin
               if (elem_ready) begin
                  if (!w_at_last) begin
                     r_idx <= r_idx + IDX_WIDTH'(1);
                  end else begin
                     r_idx <= '0;
                     if (w_accept) begin
                        r_hold <= data_in;
                     end else begin
                        r_state <= S_IDLE;
                     end
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pool_serializer.sv
// Bench for pool_serializer: random and directed vectors, scoreboard of
// expected elements checked by an independent output monitor.
module tb_pool_serializer;

   localparam int unsigned EW = 16;
   localparam int unsigned NE = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic [NE*EW-1:0]  data_in;
   logic              data_valid;
   logic              in_ready;
   logic [EW-1:0]     elem_out;
   logic              elem_valid;
   logic              elem_ready;
   logic [1:0]        elem_idx;
   logic              elem_last;
   logic              overflow;

   logic              rst1;
   logic [EW-1:0]     data_in1;
   logic              data_valid1;
   logic              in_ready1;
   logic [EW-1:0]     elem_out1;
   logic              elem_valid1;
   logic              elem_ready1;
   logic [0:0]        elem_idx1;
   logic              elem_last1;
   logic              overflow1;

   pool_serializer #(.ELEM_WIDTH(EW), .NUM_ELEMS(NE)) u_dut (
      .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
      .in_ready(in_ready), .elem_out(elem_out), .elem_valid(elem_valid),
      .elem_ready(elem_ready), .elem_idx(elem_idx), .elem_last(elem_last),
      .overflow(overflow)
   );

   pool_serializer #(.ELEM_WIDTH(EW), .NUM_ELEMS(1)) u_dut1 (
      .clk(clk), .rst(rst1), .data_in(data_in1), .data_valid(data_valid1),
      .in_ready(in_ready1), .elem_out(elem_out1), .elem_valid(elem_valid1),
      .elem_ready(elem_ready1), .elem_idx(elem_idx1), .elem_last(elem_last1),
      .overflow(overflow1)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [EW-1:0] data;
      int            idx;
      bit            last;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   hs_count = 0;
   bit   exp_ovf;
   bit   drop_now = 1'b0;
   bit   done1    = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   // Reference: a dropped vector sets the sticky flag at the next edge.
   always @(posedge clk or posedge rst) begin
      if (rst) exp_ovf <= 1'b0;
      else if (drop_now) exp_ovf <= 1'b1;
   end

   // Monitor: every handshake must match the oldest expected element.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst) begin
            check("overflow", 64'(overflow), 64'(exp_ovf));
            if (elem_valid && elem_ready) begin
               hs_count++;
               if (q.size() == 0) begin
                  check("unexpected_elem", 64'(elem_out), 64'hDEAD);
               end else begin
                  e = q.pop_front();
                  check("elem_out", 64'(elem_out), 64'(e.data));
                  check("elem_idx", 64'(elem_idx), 64'(e.idx));
                  check("elem_last", 64'(elem_last), 64'(e.last));
               end
            end
         end
      end
   end

   // One stimulus cycle; the model decides acceptance from outstanding elements.
   task automatic cycle(input bit dv, input logic [NE*EW-1:0] din, input bit rdy);
      bit acc;
      @(posedge clk);
      #1;
      data_valid = dv;
      data_in    = din;
      elem_ready = rdy;
      acc = (q.size() == 0) || (q.size() == 1 && rdy);
      #1;
      check("in_ready", 64'(in_ready), 64'(acc));
      drop_now = dv && !acc;
      if (dv && acc) begin
         for (int i = 0; i < int'(NE); i++) begin
            exp_t e;
            e.data = din[i*EW +: EW];
            e.idx  = i;
            e.last = (i == int'(NE) - 1);
            q.push_back(e);
         end
      end
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b1);
   endtask

   // Watchdog.
   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   // Single-element build: every element is last, new vector each handshake.
   initial begin
      rst1 = 1'b1; data_in1 = '0; data_valid1 = 1'b0; elem_ready1 = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst1 = 1'b0;
      @(posedge clk); #1;
      data_valid1 = 1'b1; data_in1 = 16'h00AA;
      @(posedge clk); #1;
      data_in1 = 16'h00BB;
      #1;
      check("n1_out_a", 64'(elem_out1), 64'h00AA);
      check("n1_last_a", 64'(elem_last1), 64'h1);
      check("n1_ready_a", 64'(in_ready1), 64'h1);
      @(posedge clk); #1;
      data_valid1 = 1'b0;
      #1;
      check("n1_out_b", 64'(elem_out1), 64'h00BB);
      check("n1_last_b", 64'(elem_last1), 64'h1);
      check("n1_valid_b", 64'(elem_valid1), 64'h1);
      @(posedge clk); #2;
      check("n1_valid_end", 64'(elem_valid1), 64'h0);
      check("n1_overflow", 64'(overflow1), 64'h0);
      done1 = 1'b1;
   end

   // Main stimulus.
   initial begin
      int hs0;
      int budget;
      rst = 1'b1; data_in = '0; data_valid = 1'b0; elem_ready = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_valid", 64'(elem_valid), 64'h0);
      check("rst_out", 64'(elem_out), 64'h0);
      check("rst_idx", 64'(elem_idx), 64'h0);
      check("rst_last", 64'(elem_last), 64'h0);
      check("rst_overflow", 64'(overflow), 64'h0);
      @(posedge clk); #1 rst = 1'b0;

      // Basic stream.
      cycle(1'b1, 64'h0004_0003_0002_0001, 1'b1);
      idle_cycles(5);
      check("basic_drained_valid", 64'(elem_valid), 64'h0);

      // Backpressure at index 1.
      cycle(1'b1, 64'h0004_0003_0002_0001, 1'b1);
      cycle(1'b0, '0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         cycle(1'b0, '0, 1'b0);
         check("bp_hold_out", 64'(elem_out), 64'h0002);
         check("bp_hold_idx", 64'(elem_idx), 64'h1);
      end
      idle_cycles(5);

      // Back-to-back: B arrives on A's last handshake.
      cycle(1'b1, 64'h000D_000C_000B_000A, 1'b1);
      hs0 = hs_count;
      idle_cycles(3);
      cycle(1'b1, 64'h0014_0013_0012_0011, 1'b1);
      idle_cycles(5);
      check("b2b_handshakes", 64'(hs_count - hs0), 64'd8);
      idle_cycles(2);

      // Overflow while streaming A at index 1.
      cycle(1'b1, 64'h000D_000C_000B_000A, 1'b1);
      cycle(1'b0, '0, 1'b1);
      cycle(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
      idle_cycles(6);
      check("ovf_sticky", 64'(overflow), 64'h1);

      // Reset mid-stream at index 2.
      cycle(1'b1, 64'h0024_0023_0022_0021, 1'b1);
      cycle(1'b0, '0, 1'b1);
      cycle(1'b0, '0, 1'b1);
      @(posedge clk); #1;
      check("pre_rst_idx", 64'(elem_idx), 64'h2);
      rst = 1'b1; data_valid = 1'b0; drop_now = 1'b0;
      q.delete();
      @(negedge clk);
      check("midrst_valid", 64'(elem_valid), 64'h0);
      check("midrst_idx", 64'(elem_idx), 64'h0);
      check("midrst_overflow", 64'(overflow), 64'h0);
      @(posedge clk); #1 rst = 1'b0;
      #1 check("midrst_in_ready", 64'(in_ready), 64'h1);
      cycle(1'b1, 64'h0034_0033_0032_0031, 1'b1);
      idle_cycles(5);

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         cycle($urandom_range(0, 3) == 0, {$urandom, $urandom}, $urandom_range(0, 3) != 0);
      end

      // Drain with a bounded budget.
      budget = 0;
      while (q.size() != 0 && budget < 200) begin
         cycle(1'b0, '0, 1'b1);
         budget++;
      end
      idle_cycles(2);
      check("drain_left", 64'(q.size()), 64'h0);
      check("n1_done", 64'(done1), 64'h1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
